// File: rtl/vip_bin_morph_bbox_3x3_if.sv
// Window-in / cleaned-pixel-out bundle for the binary morphology and bounding-box stage.
// The master drives the 3x3 window; the slave (the morphology block) returns results.
interface vip_bin_morph_bbox_3x3_if #(
   parameter int CNT_W = 20
);
   logic             matrix_frame_vsync;
   logic             matrix_frame_href;
   logic             matrix_frame_clken;
   logic             matrix_p11, matrix_p12, matrix_p13;
   logic             matrix_p21, matrix_p22, matrix_p23;
   logic             matrix_p31, matrix_p32, matrix_p33;
   logic             post_frame_vsync;
   logic             post_frame_href;
   logic             post_frame_clken;
   logic             post_img_bit;
   logic [10:0]      x_min, x_max, y_min, y_max;
   logic [CNT_W-1:0] pix_count;
   logic             box_valid;
   logic             frame_done;

   modport master (
      output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
             matrix_p11, matrix_p12, matrix_p13,
             matrix_p21, matrix_p22, matrix_p23,
             matrix_p31, matrix_p32, matrix_p33,
      input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit,
             x_min, x_max, y_min, y_max, pix_count, box_valid, frame_done
   );

   modport slave (
      input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
             matrix_p11, matrix_p12, matrix_p13,
             matrix_p21, matrix_p22, matrix_p23,
             matrix_p31, matrix_p32, matrix_p33,
      output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit,
             x_min, x_max, y_min, y_max, pix_count, box_valid, frame_done
   );
endinterface

// File: rtl/vip_bin_morph_bbox_3x3.sv
// 3x3 binary erosion/dilation with a 2-clk pipeline, plus per-frame foreground
// count and bounding box latched on the rising edge of the delayed vsync.
module vip_bin_morph_bbox_3x3 #(
   parameter int MODE    = 0,
   parameter int MIN_PIX = 16,
   parameter int CNT_W   = 20
) (
   input logic                      clk,
   input logic                      rst_n,
   vip_bin_morph_bbox_3x3_if.slave  bus
);

   function automatic logic red3(input logic a, input logic b, input logic c);
      return (MODE == 0) ? (a & b & c) : (a | b | c);
   endfunction

   logic [2:0]       row_d, row_q;
   logic             img_d, img_q;
   logic [1:0]       vs_d, vs_q, hr_d, hr_q, ck_d, ck_q;
   logic             vs_prev_d, vs_prev_q, hr_prev_d, hr_prev_q;
   logic [10:0]      x_d, x_q, y_d, y_q;
   logic [10:0]      ax_min_d, ax_min_q, ax_max_d, ax_max_q;
   logic [10:0]      ay_min_d, ay_min_q, ay_max_d, ay_max_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic [10:0]      x_min_d, x_min_q, x_max_d, x_max_q;
   logic [10:0]      y_min_d, y_min_q, y_max_d, y_max_q;
   logic [CNT_W-1:0] pix_count_d, pix_count_q;
   logic             box_valid_d, box_valid_q, frame_done_d, frame_done_q;
   logic             vs_rise, hr_fall, pix_en, fg;

   always_comb begin
      row_d[2] = red3(bus.matrix_p11, bus.matrix_p12, bus.matrix_p13);
      row_d[1] = red3(bus.matrix_p21, bus.matrix_p22, bus.matrix_p23);
      row_d[0] = red3(bus.matrix_p31, bus.matrix_p32, bus.matrix_p33);
      img_d    = red3(row_q[2], row_q[1], row_q[0]);
      vs_d     = {vs_q[0], bus.matrix_frame_vsync};
      hr_d     = {hr_q[0], bus.matrix_frame_href};
      ck_d     = {ck_q[0], bus.matrix_frame_clken};

      vs_rise   = vs_q[1] & ~vs_prev_q;
      hr_fall   = hr_prev_q & ~hr_q[1];
      pix_en    = hr_q[1] & ck_q[1];
      fg        = pix_en & img_q;
      vs_prev_d = vs_q[1];
      hr_prev_d = hr_q[1];

      x_d = x_q;
      y_d = y_q;
      if (vs_rise) begin
         x_d = '0;
         y_d = '0;
      end else begin
         if (hr_fall)
            x_d = '0;
         else if (pix_en && x_q != '1)
            x_d = x_q + 11'd1;
         if (hr_fall && y_q != '1)
            y_d = y_q + 11'd1;
      end

      ax_min_d     = ax_min_q;
      ax_max_d     = ax_max_q;
      ay_min_d     = ay_min_q;
      ay_max_d     = ay_max_q;
      cnt_d        = cnt_q;
      x_min_d      = x_min_q;
      x_max_d      = x_max_q;
      y_min_d      = y_min_q;
      y_max_d      = y_max_q;
      pix_count_d  = pix_count_q;
      box_valid_d  = box_valid_q;
      frame_done_d = vs_rise;

      // The frame boundary wins over a coincident pixel: that pixel is dropped.
      if (vs_rise) begin
         x_min_d     = ax_min_q;
         x_max_d     = ax_max_q;
         y_min_d     = ay_min_q;
         y_max_d     = ay_max_q;
         pix_count_d = cnt_q;
         box_valid_d = (cnt_q >= CNT_W'(MIN_PIX));
         ax_min_d    = '1;
         ax_max_d    = '0;
         ay_min_d    = '1;
         ay_max_d    = '0;
         cnt_d       = '0;
      end else if (fg) begin
         if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         if (x_q < ax_min_q) ax_min_d = x_q;
         if (x_q > ax_max_q) ax_max_d = x_q;
         if (y_q < ay_min_q) ay_min_d = y_q;
         if (y_q > ay_max_q) ay_max_d = y_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q        <= '0;
         img_q        <= 1'b0;
         vs_q         <= '0;
         hr_q         <= '0;
         ck_q         <= '0;
         vs_prev_q    <= 1'b0;
         hr_prev_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         ax_min_q     <= '1;
         ax_max_q     <= '0;
         ay_min_q     <= '1;
         ay_max_q     <= '0;
         cnt_q        <= '0;
         x_min_q      <= '1;
         x_max_q      <= '0;
         y_min_q      <= '1;
         y_max_q      <= '0;
         pix_count_q  <= '0;
         box_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         img_q        <= img_d;
         vs_q         <= vs_d;
         hr_q         <= hr_d;
         ck_q         <= ck_d;
         vs_prev_q    <= vs_prev_d;
         hr_prev_q    <= hr_prev_d;
         x_q          <= x_d;
         y_q          <= y_d;
         ax_min_q     <= ax_min_d;
         ax_max_q     <= ax_max_d;
         ay_min_q     <= ay_min_d;
         ay_max_q     <= ay_max_d;
         cnt_q        <= cnt_d;
         x_min_q      <= x_min_d;
         x_max_q      <= x_max_d;
         y_min_q      <= y_min_d;
         y_max_q      <= y_max_d;
         pix_count_q  <= pix_count_d;
         box_valid_q  <= box_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.post_frame_vsync = vs_q[1];
   assign bus.post_frame_href  = hr_q[1];
   assign bus.post_frame_clken = ck_q[1];
   assign bus.post_img_bit     = img_q & hr_q[1];
   assign bus.x_min            = x_min_q;
   assign bus.x_max            = x_max_q;
   assign bus.y_min            = y_min_q;
   assign bus.y_max            = y_max_q;
   assign bus.pix_count        = pix_count_q;
   assign bus.box_valid        = box_valid_q;
   assign bus.frame_done       = frame_done_q;

endmodule

// File: tb/tb_vip_bin_morph_bbox_3x3.sv
// Drives an erosion instance and a dilation instance with the same window stream and
// compares them against a frame-level model (pixel coordinates come from the stimulus loops).
module tb_vip_bin_morph_bbox_3x3;
   localparam int CNT_W   = 20;
   localparam int MIN_PIX = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vip_bin_morph_bbox_3x3_if #(.CNT_W(CNT_W)) if0 ();
   vip_bin_morph_bbox_3x3_if #(.CNT_W(CNT_W)) if1 ();

   vip_bin_morph_bbox_3x3 #(.MODE(0), .MIN_PIX(MIN_PIX), .CNT_W(CNT_W)) u_ero (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   vip_bin_morph_bbox_3x3 #(.MODE(1), .MIN_PIX(MIN_PIX), .CNT_W(CNT_W)) u_dil (
      .clk(clk), .rst_n(rst_n), .bus(if1));

   int n_checks = 0;
   int n_fail   = 0;

   // stimulus history, index 0 = most recent step
   logic hv [0:3];
   logic hh [0:1];
   logic hc [0:1];
   logic hb [0:1][0:1];
   // model state per instance: 0 = erosion, 1 = dilation
   int   a_xmin [0:1], a_xmax [0:1], a_ymin [0:1], a_ymax [0:1], a_cnt [0:1];
   int   p_xmin [0:1], p_xmax [0:1], p_ymin [0:1], p_ymax [0:1], p_cnt [0:1];
   int   l_xmin [0:1], l_xmax [0:1], l_ymin [0:1], l_ymax [0:1], l_cnt [0:1];
   logic l_bv [0:1];
   logic fd_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic red(input int i, input logic [8:0] t);
      return (i == 0) ? (&t) : (|t);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         a_xmin[i] = 2047; a_xmax[i] = 0; a_ymin[i] = 2047; a_ymax[i] = 0; a_cnt[i] = 0;
         p_xmin[i] = 2047; p_xmax[i] = 0; p_ymin[i] = 2047; p_ymax[i] = 0; p_cnt[i] = 0;
         l_xmin[i] = 2047; l_xmax[i] = 0; l_ymin[i] = 2047; l_ymax[i] = 0; l_cnt[i] = 0;
         l_bv[i] = 1'b0;
         hb[i][0] = 1'b0; hb[i][1] = 1'b0;
      end
      for (int k = 0; k < 4; k++) hv[k] = 1'b0;
      for (int k = 0; k < 2; k++) begin hh[k] = 1'b0; hc[k] = 1'b0; end
   endtask

   task automatic chk_inst(input int i, input logic pv, input logic ph, input logic pc,
                           input logic pb, input logic fd, input logic [10:0] xn,
                           input logic [10:0] xx, input logic [10:0] yn, input logic [10:0] yx,
                           input logic [CNT_W-1:0] cnt, input logic bv, input logic fd_e);
      check($sformatf("m%0d_vsync", i), 32'(pv), 32'(hv[1]));
      check($sformatf("m%0d_href", i),  32'(ph), 32'(hh[1]));
      check($sformatf("m%0d_clken", i), 32'(pc), 32'(hc[1]));
      check($sformatf("m%0d_bit", i),   32'(pb), 32'(hb[i][1]));
      check($sformatf("m%0d_fdone", i), 32'(fd), 32'(fd_e));
      check($sformatf("m%0d_xmin", i),  32'(xn), l_xmin[i]);
      check($sformatf("m%0d_xmax", i),  32'(xx), l_xmax[i]);
      check($sformatf("m%0d_ymin", i),  32'(yn), l_ymin[i]);
      check($sformatf("m%0d_ymax", i),  32'(yx), l_ymax[i]);
      check($sformatf("m%0d_count", i), 32'(cnt), l_cnt[i]);
      check($sformatf("m%0d_bvalid", i), 32'(bv), 32'(l_bv[i]));
   endtask

   task automatic drive(input logic v, input logic h, input logic c, input logic [8:0] t);
      if0.matrix_frame_vsync = v; if1.matrix_frame_vsync = v;
      if0.matrix_frame_href  = h; if1.matrix_frame_href  = h;
      if0.matrix_frame_clken = c; if1.matrix_frame_clken = c;
      {if0.matrix_p11, if0.matrix_p12, if0.matrix_p13, if0.matrix_p21, if0.matrix_p22,
       if0.matrix_p23, if0.matrix_p31, if0.matrix_p32, if0.matrix_p33} = t;
      {if1.matrix_p11, if1.matrix_p12, if1.matrix_p13, if1.matrix_p21, if1.matrix_p22,
       if1.matrix_p23, if1.matrix_p31, if1.matrix_p32, if1.matrix_p33} = t;
   endtask

   // One clock of stimulus: check what the DUTs show now, then apply the next inputs.
   // A pixel is accounted at (px,py) when href and clken are high; px<0 means no pixel.
   task automatic step(input logic v, input logic h, input logic c, input logic [8:0] t,
                       input int px, input int py);
      logic fd_e, rise;
      @(negedge clk);
      fd_e = hv[2] & ~hv[3];
      if (fd_e) begin
         for (int i = 0; i < 2; i++) begin
            l_xmin[i] = p_xmin[i]; l_xmax[i] = p_xmax[i];
            l_ymin[i] = p_ymin[i]; l_ymax[i] = p_ymax[i];
            l_cnt[i]  = p_cnt[i];  l_bv[i]   = (p_cnt[i] >= MIN_PIX);
         end
      end
      chk_inst(0, if0.post_frame_vsync, if0.post_frame_href, if0.post_frame_clken,
               if0.post_img_bit, if0.frame_done, if0.x_min, if0.x_max, if0.y_min,
               if0.y_max, if0.pix_count, if0.box_valid, fd_e);
      chk_inst(1, if1.post_frame_vsync, if1.post_frame_href, if1.post_frame_clken,
               if1.post_img_bit, if1.frame_done, if1.x_min, if1.x_max, if1.y_min,
               if1.y_max, if1.pix_count, if1.box_valid, fd_e);
      if (if1.frame_done) fd_seen = 1'b1;

      rise = v & ~hv[0];
      hv[3] = hv[2]; hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = v;
      hh[1] = hh[0]; hh[0] = h;
      hc[1] = hc[0]; hc[0] = c;
      for (int i = 0; i < 2; i++) begin
         hb[i][1] = hb[i][0];
         hb[i][0] = h & red(i, t);
      end
      for (int i = 0; i < 2; i++) begin
         if (rise) begin
            p_xmin[i] = a_xmin[i]; p_xmax[i] = a_xmax[i];
            p_ymin[i] = a_ymin[i]; p_ymax[i] = a_ymax[i]; p_cnt[i] = a_cnt[i];
            a_xmin[i] = 2047; a_xmax[i] = 0; a_ymin[i] = 2047; a_ymax[i] = 0; a_cnt[i] = 0;
         end else if (h && c && px >= 0 && red(i, t)) begin
            a_cnt[i]++;
            if (px < a_xmin[i]) a_xmin[i] = px;
            if (px > a_xmax[i]) a_xmax[i] = px;
            if (py < a_ymin[i]) a_ymin[i] = py;
            if (py > a_ymax[i]) a_ymax[i] = py;
         end
      end
      drive(v, h, c, t);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 9'($urandom), -1, -1);
   endtask

   function automatic logic [8:0] pattern(input int kind, input int x, input int y);
      case (kind)
         0: return ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
         1: return (x == 3 && y == 1) ? 9'h1FF : 9'h000;
         2: return (x >= 5 && x <= 24 && y >= 2 && y <= 9) ? 9'h1FF : 9'h000;
         4: return 9'h1FF;
         default: return 9'h000;
      endcase
   endfunction

   task automatic send_lines(input int w, input int nl, input int kind);
      for (int y = 0; y < nl; y++) begin
         idle(3);
         for (int x = 0; x < w; ) begin
            if ($urandom_range(0, 3) == 0) begin
               step(1'b0, 1'b1, 1'b0, 9'($urandom), -1, -1);
            end else begin
               step(1'b0, 1'b1, 1'b1, pattern(kind, x, y), x, y);
               x++;
            end
         end
      end
      idle(3);
   endtask

   task automatic send_vsync();
      fd_seen = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 9'h000, -1, -1);
      for (int k = 0; k < 8 && !fd_seen; k++) idle(1);
      check("fdone_seen", 32'(fd_seen), 32'd1);
   endtask

   task automatic do_reset(input bit chk_async);
      #2;
      drive(1'b0, 1'b0, 1'b0, 9'h000);
      rst_n = 1'b0;
      #1;
      if (chk_async) begin
         check("arst_xmin",  32'(if1.x_min), 32'd2047);
         check("arst_xmax",  32'(if1.x_max), 32'd0);
         check("arst_ymin",  32'(if1.y_min), 32'd2047);
         check("arst_ymax",  32'(if1.y_max), 32'd0);
         check("arst_count", 32'(if1.pix_count), 32'd0);
         check("arst_bvalid", 32'(if1.box_valid), 32'd0);
         check("arst_href",  32'(if1.post_frame_href), 32'd0);
      end
      model_clear();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, 9'h000);
      model_clear();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // single-window latency and tap reduction
      step(1'b0, 1'b1, 1'b1, 9'h1FF, 0, 0); idle(2);
      check("ero_all_ones", 32'(if0.post_img_bit), 32'd1);
      check("ero_clken",    32'(if0.post_frame_clken), 32'd1);
      step(1'b0, 1'b1, 1'b1, 9'h1BF, 0, 1); idle(2);
      check("ero_p13_zero", 32'(if0.post_img_bit), 32'd0);
      step(1'b0, 1'b1, 1'b1, 9'h004, 0, 2); idle(2);
      check("dil_p31",      32'(if1.post_img_bit), 32'd1);
      step(1'b0, 1'b0, 1'b1, 9'h004, -1, -1); idle(2);
      check("dil_href_low", 32'(if1.post_img_bit), 32'd0);
      idle(3);

      do_reset(1'b0);
      send_vsync();
      check("first_empty_count", 32'(if1.pix_count), 32'd0);
      check("first_empty_xmin",  32'(if1.x_min), 32'd2047);

      send_lines(8, 4, 1);
      send_vsync();
      check("f8x4_xmin",  32'(if1.x_min), 32'd3);
      check("f8x4_xmax",  32'(if1.x_max), 32'd3);
      check("f8x4_ymin",  32'(if1.y_min), 32'd1);
      check("f8x4_ymax",  32'(if1.y_max), 32'd1);
      check("f8x4_count", 32'(if1.pix_count), 32'd1);
      check("f8x4_bvalid", 32'(if1.box_valid), 32'd0);

      send_lines(32, 20, 2);
      send_vsync();
      check("f32_xmin",  32'(if1.x_min), 32'd5);
      check("f32_xmax",  32'(if1.x_max), 32'd24);
      check("f32_ymin",  32'(if1.y_min), 32'd2);
      check("f32_ymax",  32'(if1.y_max), 32'd9);
      check("f32_count", 32'(if1.pix_count), 32'd160);
      check("f32_bvalid", 32'(if1.box_valid), 32'd1);

      send_lines(16, 6, 3);
      send_vsync();
      check("empty_count", 32'(if1.pix_count), 32'd0);
      check("empty_bvalid", 32'(if1.box_valid), 32'd0);
      check("empty_xmin",  32'(if1.x_min), 32'd2047);
      check("empty_xmax",  32'(if1.x_max), 32'd0);
      check("empty_ymin",  32'(if1.y_min), 32'd2047);
      check("empty_ymax",  32'(if1.y_max), 32'd0);

      for (int f = 0; f < 3; f++) begin
         send_lines(int'($urandom_range(6, 20)), int'($urandom_range(3, 9)), 0);
         send_vsync();
      end

      // mid-frame reset: 50 foreground pixels are discarded, 20 after reset remain
      send_lines(10, 5, 4);
      do_reset(1'b1);
      send_lines(10, 2, 4);
      send_vsync();
      check("rst_count",  32'(if1.pix_count), 32'd20);
      check("rst_bvalid", 32'(if1.box_valid), 32'd1);
      check("rst_xmax",   32'(if1.x_max), 32'd9);
      check("rst_ymax",   32'(if1.y_max), 32'd1);
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
